// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the configurable UART core: parity modes, FSM states,
// baud divider calculation and the parity-bit helper.
package uart_cfg_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned bps,
                                             input int unsigned os);
        return clk_hz / (bps * os);
    endfunction

    // red is the XOR-reduction of the payload, so this works for any data width.
    function automatic logic parity_bit(input logic red, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~red : red;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// DIV x OVERSAMPLE tick counter with synchronous restart; strobes once per bit
// period when the sub-bit counter reaches STROBE_AT.
module uart_baud_cnt #(
    parameter int unsigned DIV        = 2,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STROBE_AT  = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic strobe_o
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW = $clog2(OVERSAMPLE);

    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] sub_q, sub_d;
    logic          tick;

    assign tick = (div_q == DW'(DIV - 1));

    always_comb begin
        div_d = div_q;
        sub_d = sub_q;
        if (restart_i) begin
            div_d = '0;
            sub_d = '0;
        end else if (tick) begin
            div_d = '0;
            sub_d = (sub_q == SW'(OVERSAMPLE - 1)) ? '0 : sub_q + 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            sub_q <= '0;
        end else begin
            div_q <= div_d;
            sub_q <= sub_d;
        end
    end

    assign strobe_o = tick && (sub_q == SW'(STROBE_AT));

endmodule

// File: rtl/uart_core_cfg.sv
// Full-duplex UART byte engine: configurable width/parity/stop bits, 16x
// oversampled RX with glitch reject, valid/ready on both sides.
module uart_core_cfg
    import uart_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned BPS          = 115_200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_overrun
);

    localparam int unsigned DIV = calc_div(SYS_CLK_FREQ, BPS, OVERSAMPLE);
    localparam int unsigned CW  = $clog2(DATA_WIDTH);

    // ---------------- TX ----------------
    uart_state_e           tx_state_q, tx_state_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;
    logic                  tx_accept;
    logic                  tx_strobe;

    uart_baud_cnt #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE),
        .STROBE_AT  (OVERSAMPLE - 1)
    ) u_tx_baud (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (tx_accept),
        .strobe_o  (tx_strobe)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_par_d   = tx_par_q;
        tx_accept  = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    tx_accept  = 1'b1;
                    tx_sh_d    = tx_data;
                    tx_par_d   = parity_bit(^tx_data, PARITY);
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_strobe) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_strobe) begin
                    tx_sh_d = tx_sh_q >> 1;
                    if (tx_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        tx_cnt_d   = '0;
                        tx_state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tx_strobe) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_strobe) begin
                    if (tx_cnt_q == CW'(STOP_BITS - 1)) begin
                        tx_state_d = ST_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        // Line level is registered from the next state so tx changes on the accept edge.
        tx_d = 1'b1;
        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_sh_d[0];
            ST_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (tx_state_q == ST_IDLE);

    // ---------------- RX ----------------
    logic                  sync1_q, sync2_q, prev_q;
    logic                  rx_s;
    uart_state_e           rx_state_q, rx_state_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic                  rx_par_q, rx_par_d;
    logic                  rx_restart;
    logic                  rx_strobe;
    logic                  stop_sample;

    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_pe_q, rx_pe_d;
    logic                  rx_fe_q, rx_fe_d;
    logic                  rx_ov_q, rx_ov_d;
    logic                  rx_hs;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    uart_baud_cnt #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE),
        .STROBE_AT  (OVERSAMPLE / 2 - 1)
    ) u_rx_baud (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (rx_restart),
        .strobe_o  (rx_strobe)
    );

    // prev_q tracks the line continuously, so a held-low break never looks like an edge.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_sh_d     = rx_sh_q;
        rx_cnt_d    = rx_cnt_q;
        rx_par_d    = rx_par_q;
        rx_restart  = 1'b0;
        stop_sample = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (prev_q && !rx_s) begin
                    rx_restart = 1'b1;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_strobe) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_strobe) begin
                    rx_sh_d = {rx_s, rx_sh_q[DATA_WIDTH-1:1]};
                    if (rx_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        rx_cnt_d   = '0;
                        rx_state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_strobe) begin
                    rx_par_d   = rx_s;
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_strobe) begin
                    stop_sample = 1'b1;
                    rx_state_d  = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // A handshake in the stop-sample cycle frees the register, so the new frame loads cleanly.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_pe_d    = rx_pe_q;
        rx_fe_d    = rx_fe_q;
        rx_ov_d    = rx_ov_q;
        rx_hs      = rx_valid_q && rx_ready;
        if (rx_hs) begin
            rx_valid_d = 1'b0;
            rx_ov_d    = 1'b0;
        end
        if (stop_sample) begin
            if (!rx_valid_q || rx_hs) begin
                rx_data_d  = rx_sh_q;
                rx_valid_d = 1'b1;
                rx_pe_d    = (PARITY != PARITY_NONE) &&
                             (rx_par_q != parity_bit(^rx_sh_q, PARITY));
                rx_fe_d    = !rx_s;
            end else begin
                rx_ov_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= ST_IDLE;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_pe_q    <= 1'b0;
            rx_fe_q    <= 1'b0;
            rx_ov_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_pe_q    <= rx_pe_d;
            rx_fe_q    <= rx_fe_d;
            rx_ov_q    <= rx_ov_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_pe_q;
    assign rx_frame_err  = rx_fe_q;
    assign rx_overrun    = rx_ov_q;

endmodule
